// File: rtl/rmt_pkg.sv
// Shared RMT pipeline types: PHV container and occupancy-width helper.
package rmt_pkg;

    localparam int PHV_WIDTH_DEF = 1124;

    typedef logic [PHV_WIDTH_DEF-1:0] phv_t;

    // An occupancy counter must hold DEPTH itself, hence one bit above clog2
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/phv_sync_buf_if.sv
// PHV buffer bus: valid-only write from the last stage, valid/ready read to the deparser.
interface phv_sync_buf_if
    import rmt_pkg::*;
#(
    parameter int PHV_WIDTH = PHV_WIDTH_DEF
);
    logic [PHV_WIDTH-1:0] s_phv;
    logic                 s_phv_valid;
    logic [PHV_WIDTH-1:0] m_phv;
    logic                 m_phv_valid;
    logic                 m_phv_ready;

    modport master (
        output s_phv, s_phv_valid, m_phv_ready,
        input  m_phv, m_phv_valid
    );

    modport slave (
        input  s_phv, s_phv_valid, m_phv_ready,
        output m_phv, m_phv_valid
    );
endinterface

// File: rtl/phv_sdp_ram.sv
// Simple dual-port PHV storage: one write port, one registered read port, array not reset.
module phv_sdp_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_dat_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_dat;
        if (rd_en) rd_dat_q <= mem[rd_addr];
    end

    assign rd_dat = rd_dat_q;
endmodule

// File: rtl/phv_sync_buf.sv
// PHV buffer to the deparser: SDP RAM plus 2-entry FWFT skid, write-to-valid 2 cycles when empty,
// headroom-based ingress_pause. Optional statistics (overflow_cnt, max_occ) under PHV_SYNC_STATS_EN.
module phv_sync_buf
    import rmt_pkg::*;
#(
    parameter int PHV_WIDTH = PHV_WIDTH_DEF,
    parameter int DEPTH     = 32,
    parameter int PIPE_LAT  = 8,
    parameter int CNT_W     = 32,
    localparam int AW       = $clog2(DEPTH),
    localparam int OW       = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             aresetn,
    phv_sync_buf_if.slave    phv,
    output logic             ingress_pause,
    output logic [OW-1:0]    occupancy,
    output logic             overflow_err
`ifdef PHV_SYNC_STATS_EN
    ,
    output logic [CNT_W-1:0] overflow_cnt,
    output logic [OW-1:0]    max_occ
`endif
);
    localparam logic [OW-1:0] FULL     = OW'(DEPTH);
    localparam logic [OW-1:0] PAUSE_TH = OW'(DEPTH - PIPE_LAT);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || PIPE_LAT >= DEPTH || CNT_W < 1) begin : g_bad_cfg
        $error("phv_sync_buf: unsupported DEPTH/PIPE_LAT/CNT_W");
    end

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]        ram_cnt_q, ram_cnt_d, occ_q, occ_d;
    logic [PHV_WIDTH-1:0] head_q, head_d, spare_q, spare_d, ram_rd_dat;
    logic                 head_vld_q, head_vld_d, spare_vld_q, spare_vld_d;
    logic                 rd_pend_q, rd_pend_d;
    logic                 pause_q, pause_d, err_q, err_d;
    logic                 hs, wr_acc, ovf, ram_rd;
    logic [1:0]           skid_used, slot;
    logic                 drop;
    logic [PHV_WIDTH-1:0] cand [3];
    logic [2:0]           cand_vld;

    // RAM data is shown directly while it lands so an empty buffer still meets 2-cycle latency
    assign phv.m_phv_valid = head_vld_q | rd_pend_q;
    assign phv.m_phv       = (rd_pend_q && !head_vld_q) ? ram_rd_dat : head_q;
    assign hs              = phv.m_phv_valid & phv.m_phv_ready;

    always_comb begin
        wr_acc    = phv.s_phv_valid & ((occ_q != FULL) | hs);
        ovf       = phv.s_phv_valid & ~wr_acc;
        skid_used = 2'(head_vld_q) + 2'(spare_vld_q) + 2'(rd_pend_q);
        ram_rd    = (ram_cnt_q != '0) & ((skid_used != 2'd2) | hs);

        // Compact head, spare and landing RAM word into the two skid registers after the pop
        cand[0]     = head_q;
        cand[1]     = spare_q;
        cand[2]     = ram_rd_dat;
        cand_vld    = {rd_pend_q, spare_vld_q, head_vld_q};
        head_d      = head_q;
        spare_d     = spare_q;
        head_vld_d  = 1'b0;
        spare_vld_d = 1'b0;
        drop        = hs;
        slot        = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (cand_vld[i]) begin
                if (drop) begin
                    drop = 1'b0;
                end else if (slot == 2'd0) begin
                    head_d     = cand[i];
                    head_vld_d = 1'b1;
                    slot       = 2'd1;
                end else begin
                    spare_d     = cand[i];
                    spare_vld_d = 1'b1;
                    slot        = 2'd2;
                end
            end
        end

        rd_pend_d = ram_rd;
        wr_ptr_d  = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = ram_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        ram_cnt_d = ram_cnt_q + OW'(wr_acc) - OW'(ram_rd);
        occ_d     = occ_q + OW'(wr_acc) - OW'(hs);
        pause_d   = occ_d >= PAUSE_TH;
        err_d     = err_q | ovf;
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            occ_q       <= '0;
            head_q      <= '0;
            spare_q     <= '0;
            head_vld_q  <= 1'b0;
            spare_vld_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            pause_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            occ_q       <= occ_d;
            head_q      <= head_d;
            spare_q     <= spare_d;
            head_vld_q  <= head_vld_d;
            spare_vld_q <= spare_vld_d;
            rd_pend_q   <= rd_pend_d;
            pause_q     <= pause_d;
            err_q       <= err_d;
        end
    end

    phv_sdp_ram #(
        .WIDTH (PHV_WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_dat  (phv.s_phv),
        .rd_en   (ram_rd),
        .rd_addr (rd_ptr_q),
        .rd_dat  (ram_rd_dat)
    );

    assign ingress_pause = pause_q;
    assign occupancy     = occ_q;
    assign overflow_err  = err_q;

`ifdef PHV_SYNC_STATS_EN
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [OW-1:0]    max_occ_q, max_occ_d;

    always_comb begin
        ovf_cnt_d = (ovf && ovf_cnt_q != '1) ? ovf_cnt_q + CNT_W'(1) : ovf_cnt_q;
        max_occ_d = (occ_q > max_occ_q) ? occ_q : max_occ_q;
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            ovf_cnt_q <= '0;
            max_occ_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            max_occ_q <= max_occ_d;
        end
    end

    assign overflow_cnt = ovf_cnt_q;
    assign max_occ      = max_occ_q;
`endif
endmodule

// File: tb/tb_phv_sync_buf.sv
// Bench for phv_sync_buf: directed vector table plus hand-written multi-cycle sequences.
module tb_phv_sync_buf;
    import rmt_pkg::*;

    localparam int PW       = PHV_WIDTH_DEF;
    localparam int DEPTH    = 32;
    localparam int PIPE_LAT = 8;
    localparam int CNT_W    = 32;
    localparam int OW       = occ_width(DEPTH);

    logic clk = 1'b0;
    logic aresetn;
    always #5 clk = ~clk;

    phv_sync_buf_if #(.PHV_WIDTH(PW)) bus ();

    logic          ingress_pause;
    logic [OW-1:0] occupancy;
    logic          overflow_err;
`ifdef PHV_SYNC_STATS_EN
    logic [CNT_W-1:0] overflow_cnt;
    logic [OW-1:0]    max_occ;
`endif

    phv_sync_buf #(
        .PHV_WIDTH (PW),
        .DEPTH     (DEPTH),
        .PIPE_LAT  (PIPE_LAT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .phv           (bus.slave),
        .ingress_pause (ingress_pause),
        .occupancy     (occupancy),
        .overflow_err  (overflow_err)
`ifdef PHV_SYNC_STATS_EN
        ,
        .overflow_cnt  (overflow_cnt),
        .max_occ       (max_occ)
`endif
    );

    int total = 0;
    int bad   = 0;

    phv_t          exp_q[$];
    int            mocc = 0;
    int            rx_cnt = 0;
    int            cyc_no = 0;
    int            first_rx = -1;
    int            last_rx = -1;
    logic          s_vld, s_pause, s_err;
    logic [OW-1:0] s_occ;

    function automatic phv_t mk(input logic [31:0] s);
        phv_t r;
        for (int j = 0; j < PW; j++) r[j] = s[j % 32];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic check_phv(input string name, input phv_t got, input phv_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got[31:0]=%08h want[31:0]=%08h", name, got[31:0], want[31:0]);
        end
    endtask

    // One clock: drive, sample on the falling edge, score the handshake, then advance
    task automatic cyc(input logic wr, input logic [31:0] seed, input logic rdy);
        logic hs;
        bus.s_phv_valid = wr;
        bus.s_phv       = mk(seed);
        bus.m_phv_ready = rdy;
        @(negedge clk);
        s_vld   = bus.m_phv_valid;
        s_occ   = occupancy;
        s_pause = ingress_pause;
        s_err   = overflow_err;
        hs      = bus.m_phv_valid && rdy;
        check($sformatf("occ cyc%0d", cyc_no), s_occ, mocc);
        if (hs) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx unexpected: got output with empty scoreboard at cyc%0d", cyc_no);
            end else begin
                check_phv($sformatf("rx data cyc%0d", cyc_no), bus.m_phv, exp_q.pop_front());
                rx_cnt++;
                if (first_rx < 0) first_rx = cyc_no;
                last_rx = cyc_no;
            end
        end
        if (wr && (mocc < DEPTH || hs)) begin
            exp_q.push_back(mk(seed));
            mocc++;
        end
        if (hs) mocc--;
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            cyc(1'b0, 32'h0, 1'b1);
            n++;
        end
        check({name, " drained"}, exp_q.size(), 0);
    endtask

    typedef struct {
        logic          wr;
        logic [31:0]   seed;
        logic          rdy;
        logic          exp_vld;
        logic [31:0]   exp_seed;
        logic [OW-1:0] exp_occ;
        logic          exp_pause;
    } vec_t;

    vec_t vt [13];

    initial begin
        vt[0]  = '{1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0,        6'd0, 1'b0};
        vt[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        6'd1, 1'b0};
        vt[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hA5A5A5A5, 6'd1, 1'b0};
        vt[3]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        6'd0, 1'b0};
        vt[4]  = '{1'b1, 32'h11,       1'b0, 1'b0, 32'h0,        6'd0, 1'b0};
        vt[5]  = '{1'b1, 32'h22,       1'b0, 1'b0, 32'h0,        6'd1, 1'b0};
        vt[6]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h11,       6'd2, 1'b0};
        vt[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h11,       6'd2, 1'b0};
        vt[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h22,       6'd1, 1'b0};
        vt[9]  = '{1'b1, 32'h33,       1'b1, 1'b0, 32'h0,        6'd0, 1'b0};
        vt[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        6'd1, 1'b0};
        vt[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h33,       6'd1, 1'b0};
        vt[12] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        6'd0, 1'b0};

        aresetn         = 1'b0;
        bus.s_phv_valid = 1'b0;
        bus.s_phv       = '0;
        bus.m_phv_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 aresetn = 1'b1;

        @(negedge clk);
        check("reset vld", bus.m_phv_valid, 0);
        check("reset occ", occupancy, 0);
        check("reset pause", ingress_pause, 0);
        check("reset err", overflow_err, 0);
        check("reset m_phv", bus.m_phv[63:0], 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            bus.s_phv_valid = vt[i].wr;
            bus.s_phv       = mk(vt[i].seed);
            bus.m_phv_ready = vt[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d vld", i), bus.m_phv_valid, vt[i].exp_vld);
            if (vt[i].exp_vld) check_phv($sformatf("vec%0d data", i), bus.m_phv, mk(vt[i].exp_seed));
            check($sformatf("vec%0d occ", i), occupancy, vt[i].exp_occ);
            check($sformatf("vec%0d pause", i), ingress_pause, vt[i].exp_pause);
            @(posedge clk);
            #1;
        end

        // 64 back-to-back writes, ready held high
        rx_cnt = 0;
        first_rx = -1;
        for (int k = 0; k < 64; k++) cyc(1'b1, 32'h100 + k, 1'b1);
        drain("b2b");
        check("b2b rx count", rx_cnt, 64);
        check("b2b no gaps", last_rx - first_rx, 63);
        check("b2b err", overflow_err, 0);

        // Headroom pause at DEPTH-PIPE_LAT
        for (int k = 0; k < 24; k++) begin
            cyc(1'b1, 32'h200 + k, 1'b0);
            if (k == 23) begin
                check("pause occ23", s_occ, 23);
                check("pause low at 23", s_pause, 0);
            end
        end
        cyc(1'b0, 32'h0, 1'b0);
        check("pause occ24", s_occ, 24);
        check("pause high at 24", s_pause, 1);
        cyc(1'b0, 32'h0, 1'b1);
        check("pause held before pop", s_pause, 1);
        cyc(1'b0, 32'h0, 1'b0);
        check("drain occ23", s_occ, 23);
        check("pause drop at 23", s_pause, 0);
        drain("pause");

        // Overflow: 34 writes into a 32-deep buffer with no reads
        for (int k = 0; k < 34; k++) begin
            cyc(1'b1, 32'h300 + k, 1'b0);
            if (k == 32) check("ovf err before drop", s_err, 0);
        end
        cyc(1'b0, 32'h0, 1'b0);
        check("ovf occ", s_occ, 32);
        check("ovf err", s_err, 1);
        check("ovf pause", s_pause, 1);
`ifdef PHV_SYNC_STATS_EN
        check("ovf cnt", overflow_cnt, 2);
        check("max occ", max_occ, 32);
`endif

        // Full buffer: write plus handshake in the same cycle
        cyc(1'b1, 32'h999, 1'b1);
        check("full wr+rd vld", s_vld, 1);
        cyc(1'b0, 32'h0, 1'b0);
        check("full wr+rd occ", s_occ, 32);
        check("full wr+rd err sticky", s_err, 1);
`ifdef PHV_SYNC_STATS_EN
        check("full wr+rd cnt", overflow_cnt, 2);
`endif
        drain("full");

        // Reset with 10 entries held
        for (int k = 0; k < 10; k++) cyc(1'b1, 32'h500 + k, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        check("pre-reset occ", s_occ, 10);
        bus.s_phv_valid = 1'b0;
        aresetn = 1'b0;
        @(posedge clk);
        #1 aresetn = 1'b1;
        exp_q.delete();
        mocc = 0;
        @(negedge clk);
        check("rst vld", bus.m_phv_valid, 0);
        check("rst occ", occupancy, 0);
        check("rst pause", ingress_pause, 0);
        check("rst err", overflow_err, 0);
`ifdef PHV_SYNC_STATS_EN
        check("rst max occ", max_occ, 0);
        check("rst ovf cnt", overflow_cnt, 0);
`endif
        @(posedge clk);
        #1;
        cyc(1'b0, 32'h0, 1'b1);
        check("post-rst vld", s_vld, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/phv_sync_buf.md
# phv_sync_buf

Parametrised PHV buffer between the last match-action stage and the deparser. It replaces the fixed pair of split-width PHV FIFOs with one PHV_WIDTH-wide buffer that has a configurable depth and a first-word-fall-through valid/ready output. It adds headroom-based ingress backpressure that accounts for PHVs still in flight in the stages, plus overflow detection. Stages cannot stall, so the write side is valid-only; the read side is a normal handshake toward the deparser.

## Interface
- PHV_WIDTH, 1124, PHV bit width
- DEPTH, 32, entries; power of two, >= 4
- PIPE_LAT, 8, maximum number of PHVs that can be in flight between ingress pause and buffer write; sets the headroom
- CNT_W, 32, statistics counter width
- clk  in  1  clock
- aresetn  in  1  reset; synchronous, active-low
- s_phv  in  PHV_WIDTH  PHV from the last stage
- s_phv_valid  in  1  single-cycle write strobe; no ready
- m_phv  out  PHV_WIDTH  head PHV to the deparser
- m_phv_valid  out  1  head valid
- m_phv_ready  in  1  deparser consumes the head
- ingress_pause  out  1  registered; upstream deasserts tready while this is high
- occupancy  out  $clog2(DEPTH)+1  entries held, including the output register
- overflow_err  out  1  sticky; set on a dropped write
- overflow_cnt  out  CNT_W  dropped writes (present only with PHV_SYNC_STATS_EN)
- max_occ  out  $clog2(DEPTH)+1  occupancy high-water mark (present only with PHV_SYNC_STATS_EN)

## Operation
- Storage: DEPTH-entry simple-dual-port RAM with a registered read, followed by a 2-entry output skid (head register plus spare register), which gives full 1/cycle throughput under FWFT.
- Total capacity is DEPTH; occupancy counts RAM entries plus skid entries.
- Write: if s_phv_valid and occupancy < DEPTH, store the PHV. If occupancy == DEPTH and a read handshake occurs in the same cycle, the write is also accepted.
- Overflow: a write with occupancy == DEPTH and no read in that cycle is dropped. overflow_err is set and overflow_cnt increments, saturating at all-ones.
- Prefetch: the RAM read is issued whenever the RAM is non-empty and the skid has a free slot, counting a slot freed by this cycle's handshake. The read data lands in the skid the following cycle.
- Read: on m_phv_valid & m_phv_ready the head advances to the spare register, or becomes invalid if the spare is empty. m_phv is stable while valid and not ready.
- Pause: ingress_pause_next = (occupancy_next >= DEPTH - PIPE_LAT). This is a compare on the post-update occupancy, registered.
- Pointers: rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap naturally. RAM full/empty state is derived from a separate RAM count, not from pointer equality.
- Reset: pointers, counts, skid valids, overflow_err, statistics and ingress_pause all clear to 0. m_phv resets to 0. RAM contents are not reset.
- Reset asserted mid-operation discards all stored PHVs. No output is valid in the cycle after reset deasserts.

## Timing
- Write-to-output latency when empty: write in cycle N, m_phv_valid high in N+2.
- Sustained throughput: 1 PHV/cycle with m_phv_ready held high.
- occupancy, ingress_pause and overflow_err update on the clock edge after the causing event.
- Handshake: m_phv_valid never drops without a handshake, and m_phv_ready is not required before m_phv_valid.
- Simultaneous write and read at occupancy DEPTH: both accepted and occupancy unchanged; no overflow.
- Simultaneous write and read when empty: no handshake is possible (valid is low), so the write is stored.

## Configuration
- PHV_SYNC_STATS_EN defined: overflow_cnt and max_occ are present. max_occ updates to occupancy whenever occupancy > max_occ. Both clear only on reset.
- PHV_SYNC_STATS_EN undefined: both ports are absent and no statistics logic is generated. overflow_err is always present.

## Structure
- The shared package rmt_pkg holds:
  - PHV_WIDTH_DEF = 1124
  - the occupancy width function (clog2 + 1)
  - the phv_t typedef, a packed PHV_WIDTH vector
- One sub-module, phv_sdp_ram: parametrised width and depth, one write port, one read port with a registered read, no reset on the array.
- The skid, pointers, counters and pause logic live in phv_sync_buf.

## Test plan
- Single PHV 0xA5 pattern written while empty, ready high -> m_phv_valid in cycle N+2 with data equal, occupancy back to 0 one cycle after the handshake.
- 64 back-to-back writes with ready held high, DEPTH=32 -> all 64 emerged in order, no gaps after the first, overflow_err = 0.
- Ready low, write 24 (DEPTH=32, PIPE_LAT=8) -> ingress_pause rises the cycle after occupancy hits 24; draining to 23 drops it one cycle later.
- Ready low, write 34 -> occupancy 32, overflow_err = 1, overflow_cnt = 2; the first 32 PHVs are output in order.
- Occupancy 32, write plus handshake in the same cycle -> occupancy stays 32, no overflow, new PHV emerges last.
- Reset pulse with 10 entries held -> next cycle m_phv_valid = 0, occupancy = 0, ingress_pause = 0, overflow_err = 0, max_occ = 0.
